// File: rtl/display_sequencer.sv
// Result-display sequencer: snapshots NUM_GROUPS x ELEMS result elements and streams them out
// with valid/ready, group/index tags, abort and a done pulse. Define DISPLAY_LOOP_EN to repeat passes.
module display_sequencer #(
    parameter  int DATA_W     = 8,
    parameter  int NUM_GROUPS = 3,
    parameter  int ELEMS      = 4,
    localparam int TOTAL      = NUM_GROUPS * ELEMS,
    localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int EW         = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_display,
    input  logic                    display_abort_i,
    input  logic [TOTAL*DATA_W-1:0] result_data_i,
    input  logic                    display_ready_i,
    output logic [DATA_W-1:0]       display_result_o,
    output logic                    display_valid_o,
    output logic [GW-1:0]           display_group_o,
    output logic [EW-1:0]           display_index_o,
    output logic [1:0]              state_display_o,
    output logic                    display_done_o
);

    localparam int PW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic              last_elem;
    logic              transfer;
    logic [DATA_W-1:0] mem [TOTAL];

    assign ptr_next        = ptr + PW'(1);
    assign last_elem       = (ptr == PW'(TOTAL - 1));
    assign transfer        = display_valid_o & display_ready_i;
    assign state_display_o = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            display_valid_o  <= 1'b0;
            display_result_o <= '0;
            display_group_o  <= '0;
            display_index_o  <= '0;
            display_done_o   <= 1'b0;
            // NOTE: the snapshot memory is reset too, so nothing from a pre-reset pass can be replayed.
            for (int k = 0; k < TOTAL; k++) begin
                mem[k] <= '0;
            end
        end else begin
            display_done_o <= 1'b0;
            if (display_abort_i) begin
                state            <= ST_IDLE;
                ptr              <= '0;
                display_valid_o  <= 1'b0;
                display_result_o <= '0;
                display_group_o  <= '0;
                display_index_o  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_display) begin
                            for (int k = 0; k < TOTAL; k++) begin
                                mem[k] <= result_data_i[k*DATA_W +: DATA_W];
                            end
                            // Element 0 comes straight from the input so valid appears one cycle after start.
                            state            <= ST_SHOW;
                            ptr              <= '0;
                            display_valid_o  <= 1'b1;
                            display_result_o <= result_data_i[DATA_W-1:0];
                            display_group_o  <= '0;
                            display_index_o  <= '0;
                        end
                    end
                    ST_SHOW: begin
                        if (transfer) begin
                            if (last_elem) begin
                                ptr             <= '0;
                                display_group_o <= '0;
                                display_index_o <= '0;
                                display_done_o  <= 1'b1;
`ifdef DISPLAY_LOOP_EN
                                display_result_o <= mem[0];
`else
                                state            <= ST_DONE;
                                display_valid_o  <= 1'b0;
                                display_result_o <= '0;
`endif
                            end else begin
                                ptr              <= ptr_next;
                                display_result_o <= mem[ptr_next];
                                // Group/index counter pair tracks ptr without a divider.
                                if (display_index_o == EW'(ELEMS - 1)) begin
                                    display_index_o <= '0;
                                    display_group_o <= display_group_o + GW'(1);
                                end else begin
                                    display_index_o <= display_index_o + EW'(1);
                                end
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
